// File: rtl/multicycle_divider_if.sv
// Request/response bundle for the multicycle divider: operands and start in,
// registered quotient/remainder plus done/busy status out.
interface multicycle_divider_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             calc;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             busy;

    modport master (output a, b, is_signed, calc,
                    input  quotient, remainder, done, busy);
    modport slave  (input  a, b, is_signed, calc,
                    output quotient, remainder, done, busy);
endinterface

// File: rtl/multicycle_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: WIDTH iterations on operand
// magnitudes, sign fix-up on the last step; divide-by-zero and overflow take one cycle.
module multicycle_divider #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_divider_if.slave div_if
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] part_q;     // partial remainder
    logic [WIDTH-1:0] dvd_q;      // dividend magnitude, turns into the quotient
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [CW-1:0]    cnt_q;
    logic             q_neg_q, r_neg_q;
    logic [WIDTH-1:0] quot_q, rem_q;

    logic             div_zero, ovf, last;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   shifted, trial;
    logic             qbit;
    logic [WIDTH-1:0] part_d, dvd_d;

    assign div_zero = (div_if.b == '0);
    assign ovf      = div_if.is_signed && (div_if.a == {1'b1, {(WIDTH-1){1'b0}}})
                      && (div_if.b == '1);
    assign abs_a    = (div_if.is_signed && div_if.a[WIDTH-1]) ? -div_if.a : div_if.a;
    assign abs_b    = (div_if.is_signed && div_if.b[WIDTH-1]) ? -div_if.b : div_if.b;
    assign last     = (cnt_q == CW'(WIDTH-1));

    // One restoring step; the extra top bit of the trial acts as the borrow.
    always_comb begin
        shifted = {part_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        qbit    = ~trial[WIDTH];
        part_d  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_d   = {dvd_q[WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (div_if.calc) state_d = (div_zero || ovf) ? DONE : ITER;
            ITER:    if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_if.done = (state_q == DONE);
        div_if.busy = (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            part_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (div_if.calc) begin
                    if (div_zero) begin
                        quot_q <= '1;
                        rem_q  <= div_if.a;
                    end else if (ovf) begin
                        quot_q <= div_if.a;
                        rem_q  <= '0;
                    end else begin
                        dvd_q   <= abs_a;
                        dvs_q   <= abs_b;
                        q_neg_q <= div_if.is_signed & (div_if.a[WIDTH-1] ^ div_if.b[WIDTH-1]);
                        r_neg_q <= div_if.is_signed & div_if.a[WIDTH-1];
                        part_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                ITER: begin
                    part_q <= part_d;
                    dvd_q  <= dvd_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last) begin
                        quot_q <= q_neg_q ? -dvd_d  : dvd_d;
                        rem_q  <= r_neg_q ? -part_d : part_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_if.quotient  = quot_q;
    assign div_if.remainder = rem_q;
endmodule

// File: tb/tb_multicycle_divider.sv
// Bench for multicycle_divider: directed vector table, randomized operands against a
// plain-arithmetic reference, async reset mid-operation and held-calc back-to-back.
module tb_multicycle_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    multicycle_divider_if #(.WIDTH(W)) dif ();
    multicycle_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .div_if(dif));

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: RISC-V division rules stated directly with SV arithmetic.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output int lat);
        if (b == 0) begin
            q = '1; r = a; lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0; lat = 1;
        end else if (s) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); lat = W + 1;
        end else begin
            q = a / b; r = a % b; lat = W + 1;
        end
    endfunction

    // Issue one op with a single-cycle calc, scramble operands afterwards, and check
    // done latency, busy length, results and the single-cycle done pulse.
    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int lat);
        int dn = 0;
        int bc = 0;
        @(negedge clk);
        dif.a = a; dif.b = b; dif.is_signed = s; dif.calc = 1'b1;
        for (int n = 1; n <= W + 8; n++) begin
            @(negedge clk);
            dif.calc = 1'b0;
            dif.a = $urandom; dif.b = $urandom; dif.is_signed = $urandom_range(0, 1);
            if (dif.busy) bc++;
            if (dif.done) begin dn = n; break; end
        end
        chk({nm, " done_latency"}, 64'(dn), 64'(lat));
        chk({nm, " busy_cycles"}, 64'(bc), 64'(lat));
        chk({nm, " quotient"}, 64'(dif.quotient), 64'(eq));
        chk({nm, " remainder"}, 64'(dif.remainder), 64'(er));
        @(negedge clk);
        chk({nm, " done_busy_after"}, {62'd0, dif.done, dif.busy}, 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rq, rr, q1, r1, a1, b1;
        logic         rs;
        int           rl, dp, d1, d2;

        tv[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33};
        tv[1] = '{32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        tv[2] = '{32'd7,          32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,          33};
        tv[3] = '{32'h1234_5678, 32'd0,          1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1};
        tv[4] = '{32'h1234_5678, 32'd0,          1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1};
        tv[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,          1};
        tv[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,          32'h8000_0000, 33};
        tv[7] = '{32'hFFFF_FF9C, 32'd7,          1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33};
        tv[8] = '{32'hFFFF_FFFF, 32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0,          33};
        tv[9] = '{32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          33};

        dif.a = '0; dif.b = '0; dif.is_signed = 1'b0; dif.calc = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {dif.quotient, dif.remainder}, 64'd0);
        chk("reset done_busy", {62'd0, dif.done, dif.busy}, 64'd0);
        rst = 1'b0;

        foreach (tv[i]) do_op($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].s,
                              tv[i].q, tv[i].r, tv[i].lat);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom; rs = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = $urandom_range(1, 15);
                2:       begin ra = 32'h8000_0000; rb = '1; end
                3:       rb = -$urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            ref_div(ra, rb, rs, rq, rr, rl);
            do_op($sformatf("rand%0d", i), ra, rb, rs, rq, rr, rl);
        end

        // Async reset 10 cycles into an ITER; previous results are nonzero.
        @(negedge clk);
        dif.a = 32'd100; dif.b = 32'd7; dif.is_signed = 1'b0; dif.calc = 1'b1;
        repeat (10) begin @(negedge clk); dif.calc = 1'b0; end
        #2 rst = 1'b1;
        #1;
        chk("rst_mid quotient", 64'(dif.quotient), 64'd0);
        chk("rst_mid remainder", 64'(dif.remainder), 64'd0);
        chk("rst_mid done_busy", {62'd0, dif.done, dif.busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("post_rst", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 33);

        // calc held high, operands churning; second accept in the IDLE cycle after DONE.
        a1 = 32'hFFFF_FC18; b1 = 32'd37;   // -1000 / 37 signed
        ref_div(32'hDEAD_BEEF, 32'd1234, 1'b0, rq, rr, rl);
        ref_div(a1, b1, 1'b1, q1, r1, rl);
        dp = 0; d1 = 0; d2 = 0;
        @(negedge clk);
        dif.a = 32'hDEAD_BEEF; dif.b = 32'd1234; dif.is_signed = 1'b0; dif.calc = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (dif.done) begin
                dp++;
                if (d1 == 0) begin
                    d1 = n;
                    chk("held q0", 64'(dif.quotient), 64'(rq));
                    chk("held r0", 64'(dif.remainder), 64'(rr));
                end else if (d2 == 0) begin
                    d2 = n;
                    chk("held q1", 64'(dif.quotient), 64'(q1));
                    chk("held r1", 64'(dif.remainder), 64'(r1));
                end
            end
            if (n == 34) begin
                chk("held idle_gap busy", 64'(dif.busy), 64'd0);
                dif.a = a1; dif.b = b1; dif.is_signed = 1'b1;
            end else begin
                dif.a = $urandom; dif.b = $urandom; dif.is_signed = $urandom_range(0, 1);
            end
            if (n == 60) dif.calc = 1'b0;
        end
        chk("held first_done", 64'(d1), 64'd33);
        chk("held second_done", 64'(d2), 64'd67);
        chk("held done_pulses", 64'(dp), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
